// File: rtl/morse_letter_assembler_pkg.sv
// Shared types and helpers for the Morse letter assembler.
//   state_t       : assembler FSM states
//   MORSE_DOT/DASH: element encodings in sym_code
//   len_width()   : width of the element-count field for a given MAX_SYMS
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic MORSE_DOT  = 1'b0;
  localparam logic MORSE_DASH = 1'b1;

  function automatic int unsigned len_width(input int unsigned max_syms);
    return $clog2(max_syms + 1);
  endfunction

endpackage

// File: rtl/morse_letter_assembler_dur_counter.sv
// Saturating duration counter, counting enabled ticks.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart at 0 (wins over en)
//   en       : advance by one, holding at all-ones
//   cnt      : current count
module morse_dur_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/morse_letter_assembler.sv
// Morse letter assembler: times key marks/spaces in ticks, classifies marks
// as dot/dash, collects up to MAX_SYMS elements and presents each finished
// letter through a one-entry valid/ready buffer.
//   clk, rst   : clock, asynchronous active-high reset
//   tick       : timebase enable
//   key_in     : debounced key level (1 = down)
//   sym_ready  : downstream accepts the buffered letter
//   sym_valid  : buffer holds a letter
//   sym_code   : elements, newest at bit0, dash=1, unused upper bits 0
//   sym_len    : element count of the buffered letter
//   overflow   : sticky, a letter had more than MAX_SYMS elements
//   overrun    : sticky, a letter completed while the buffer was full
//   busy       : FSM not idle
//   word_gap   : (MORSE_WORD_GAP_EN only) one-cycle word boundary pulse
// Build option: define MORSE_WORD_GAP_EN to add word_gap detection.
module morse_letter_assembler
  import morse_pkg::*;
#(
  parameter int unsigned MAX_SYMS         = 6,
  parameter int unsigned CNT_W            = 8,
  parameter int unsigned GLITCH_TICKS     = 1,
  parameter int unsigned DASH_TICKS       = 3,
  parameter int unsigned LETTER_GAP_TICKS = 3
`ifdef MORSE_WORD_GAP_EN
  ,
  parameter int unsigned WORD_GAP_TICKS   = 7
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tick,
  input  logic                              key_in,
  input  logic                              sym_ready,
  output logic                              sym_valid,
  output logic [MAX_SYMS-1:0]               sym_code,
  output logic [len_width(MAX_SYMS)-1:0]    sym_len,
  output logic                              overflow,
  output logic                              overrun,
`ifdef MORSE_WORD_GAP_EN
  output logic                              word_gap,
`endif
  output logic                              busy
);

  localparam int unsigned LEN_W = len_width(MAX_SYMS);
  localparam logic [LEN_W-1:0] MAX_C      = LEN_W'(MAX_SYMS);
  localparam logic [CNT_W-1:0] GLITCH_C   = CNT_W'(GLITCH_TICKS);
  localparam logic [CNT_W-1:0] DASH_C     = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] LGAP_LAST  = CNT_W'(LETTER_GAP_TICKS - 1);

  state_t              state, state_next;
  logic                key_q;
  logic                rise, fall;
  logic [MAX_SYMS-1:0] code_q, code_next;
  logic [LEN_W-1:0]    len_q, len_next;
  logic [CNT_W-1:0]    mark_cnt, space_cnt;
  logic                mark_clr, mark_en, space_clr, space_en;
  logic                ovf_set, complete, load, elem;

  assign rise = key_in & ~key_q;
  assign fall = ~key_in & key_q;
  assign elem = (mark_cnt >= DASH_C) ? MORSE_DASH : MORSE_DOT;
  assign busy = (state != IDLE);

  morse_dur_counter #(.CNT_W(CNT_W)) u_mark_cnt (
    .clk (clk),
    .rst (rst),
    .clr (mark_clr),
    .en  (mark_en),
    .cnt (mark_cnt)
  );

  morse_dur_counter #(.CNT_W(CNT_W)) u_space_cnt (
    .clk (clk),
    .rst (rst),
    .clr (space_clr),
    .en  (space_en),
    .cnt (space_cnt)
  );

  always_comb begin
    state_next = state;
    code_next  = code_q;
    len_next   = len_q;
    mark_clr   = 1'b0;
    mark_en    = 1'b0;
    space_clr  = 1'b0;
    space_en   = 1'b0;
    ovf_set    = 1'b0;
    complete   = 1'b0;
    unique case (state)
      IDLE: begin
`ifdef MORSE_WORD_GAP_EN
        space_en = tick;
`endif
        if (rise) begin
          state_next = MARK;
          mark_clr   = 1'b1;
        end
      end
      MARK: begin
        mark_en = tick;
        if (fall) begin
          state_next = GAP;
          space_clr  = 1'b1;
          if (mark_cnt >= GLITCH_C) begin
            if (len_q < MAX_C) begin
              code_next = {code_q[MAX_SYMS-2:0], elem};
              len_next  = len_q + LEN_W'(1);
            end else begin
              ovf_set = 1'b1;
            end
          end
        end
      end
      GAP: begin
        space_en = tick;
        // Gap completion and a simultaneous key rise: the current letter is
        // latched first, then the rise starts a fresh letter from empty.
        if (tick && (space_cnt == LGAP_LAST)) begin
          complete   = (len_q != '0);
          code_next  = '0;
          len_next   = '0;
          state_next = rise ? MARK : IDLE;
          mark_clr   = rise;
        end else if (rise) begin
          state_next = MARK;
          mark_clr   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign load = complete && (!sym_valid || sym_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_q     <= 1'b0;
      code_q    <= '0;
      len_q     <= '0;
      sym_valid <= 1'b0;
      sym_code  <= '0;
      sym_len   <= '0;
      overflow  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state  <= state_next;
      key_q  <= key_in;
      code_q <= code_next;
      len_q  <= len_next;
      if (ovf_set) begin
        overflow <= 1'b1;
      end
      if (complete && !load) begin
        overrun <= 1'b1;
      end
      if (load) begin
        sym_valid <= 1'b1;
        sym_code  <= code_q;
        sym_len   <= len_q;
      end else if (sym_ready) begin
        sym_valid <= 1'b0;
      end
    end
  end

`ifdef MORSE_WORD_GAP_EN
  localparam logic [CNT_W-1:0] WGAP_LAST = CNT_W'(WORD_GAP_TICKS - 1);
  logic wg_armed;

  // Armed by a completed letter; fires once when the continuing space count
  // reaches WORD_GAP_TICKS while idle, and is disarmed by any key rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wg_armed <= 1'b0;
      word_gap <= 1'b0;
    end else begin
      word_gap <= 1'b0;
      if (complete) begin
        wg_armed <= !rise;
      end else if (rise) begin
        wg_armed <= 1'b0;
      end else if (wg_armed && (state == IDLE) && tick && (space_cnt == WGAP_LAST)) begin
        word_gap <= 1'b1;
        wg_armed <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_morse_letter_assembler.sv
module tb_morse_letter_assembler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic       key_in = 1'b0;
  logic       sym_ready = 1'b0;
  logic       sym_valid;
  logic [5:0] sym_code;
  logic [2:0] sym_len;
  logic       overflow;
  logic       overrun;
  logic       busy;
`ifdef MORSE_WORD_GAP_EN
  logic       word_gap;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  morse_letter_assembler #(
    .MAX_SYMS(6),
    .CNT_W(8),
    .GLITCH_TICKS(1),
    .DASH_TICKS(3),
    .LETTER_GAP_TICKS(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .key_in    (key_in),
    .sym_ready (sym_ready),
    .sym_valid (sym_valid),
    .sym_code  (sym_code),
    .sym_len   (sym_len),
    .overflow  (overflow),
    .overrun   (overrun),
`ifdef MORSE_WORD_GAP_EN
    .word_gap  (word_gap),
`endif
    .busy      (busy)
  );

  typedef struct {
    int unsigned n;
    int unsigned marks[7];
    bit          hold_ready;
    logic [5:0]  code;
    logic [2:0]  len;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n clocks; returns 1 time unit after the last rising edge.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A mark of n ticks: key high for n+1 cycles (rise cycle does not count).
  task automatic mark(input int unsigned n);
    key_in = 1'b1;
    step(n + 1);
  endtask

  task automatic space(input int unsigned n);
    key_in = 1'b0;
    step(n + 1);
  endtask

  initial begin
    int unsigned wg_cnt;
    int unsigned wg_at;

    vecs[0] = '{2, '{1, 3, 0, 0, 0, 0, 0}, 1'b0, 6'b000001, 3'd2};
    vecs[1] = '{4, '{3, 1, 3, 1, 0, 0, 0}, 1'b1, 6'b001010, 3'd4};
    vecs[2] = '{1, '{20, 0, 0, 0, 0, 0, 0}, 1'b0, 6'b000001, 3'd1};
    vecs[3] = '{2, '{2, 3, 0, 0, 0, 0, 0}, 1'b1, 6'b000001, 3'd2};
    vecs[4] = '{3, '{1, 0, 3, 0, 0, 0, 0}, 1'b0, 6'b000001, 3'd2};
    vecs[5] = '{6, '{3, 3, 3, 3, 3, 1, 0}, 1'b0, 6'b111110, 3'd6};

    #12;
    chk("reset_valid", {31'd0, sym_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_len", {29'd0, sym_len}, 32'd0);
    chk("reset_code", {26'd0, sym_code}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(2);

    // Table: letters with 1-tick intra-letter spaces, then letter gap.
    for (int v = 0; v < 6; v++) begin
      sym_ready = vecs[v].hold_ready;
      for (int unsigned i = 0; i < vecs[v].n; i++) begin
        if (i > 0) space(1);
        mark(vecs[v].marks[i]);
      end
      key_in = 1'b0;
      step(3);
      chk($sformatf("v%0d_valid_early", v), {31'd0, sym_valid}, 32'd0);
      step(1);
      chk($sformatf("v%0d_valid", v), {31'd0, sym_valid}, 32'd1);
      chk($sformatf("v%0d_len", v), {29'd0, sym_len}, {29'd0, vecs[v].len});
      chk($sformatf("v%0d_code", v), {26'd0, sym_code}, {26'd0, vecs[v].code});
      chk($sformatf("v%0d_overflow", v), {31'd0, overflow}, 32'd0);
      chk($sformatf("v%0d_overrun", v), {31'd0, overrun}, 32'd0);
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
      if (!vecs[v].hold_ready) begin
        step(2);
        chk($sformatf("v%0d_valid_hold", v), {31'd0, sym_valid}, 32'd1);
        sym_ready = 1'b1;
      end
      step(1);
      sym_ready = 1'b0;
      chk($sformatf("v%0d_valid_drop", v), {31'd0, sym_valid}, 32'd0);
      chk($sformatf("v%0d_code_held", v), {26'd0, sym_code}, {26'd0, vecs[v].code});
      step(1);
    end

    // All-glitch letter: key high for one cycle only.
    key_in = 1'b1;
    step(1);
    key_in = 1'b0;
    step(1);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    step(3);
    chk("glitch_idle", {31'd0, busy}, 32'd0);
    step(3);
    chk("glitch_valid", {31'd0, sym_valid}, 32'd0);

    // Seven dots with nobody reading: overflow, six dots kept.
    for (int i = 0; i < 7; i++) begin
      if (i > 0) space(1);
      mark(1);
    end
    key_in = 1'b0;
    step(4);
    chk("ovf_valid", {31'd0, sym_valid}, 32'd1);
    chk("ovf_len", {29'd0, sym_len}, 32'd6);
    chk("ovf_code", {26'd0, sym_code}, 32'd0);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_overrun", {31'd0, overrun}, 32'd0);

    // Second letter "E" while the first is unread: overrun.
    mark(1);
    key_in = 1'b0;
    step(4);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_valid", {31'd0, sym_valid}, 32'd1);
    chk("ovr_len", {29'd0, sym_len}, 32'd6);
    chk("ovr_code", {26'd0, sym_code}, 32'd0);
    step(5);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Asynchronous reset mid-MARK with a letter still pending.
    key_in = 1'b1;
    step(2);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, sym_valid}, 32'd0);
    chk("rst_len", {29'd0, sym_len}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    key_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(2);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

`ifdef MORSE_WORD_GAP_EN
    // Letter "E" then idle: single word_gap pulse seven ticks into the space.
    mark(1);
    key_in = 1'b0;
    step(1);
    wg_cnt = 0;
    wg_at = 0;
    for (int unsigned i = 1; i <= 10; i++) begin
      step(1);
      if (word_gap) begin
        wg_cnt++;
        wg_at = i;
      end
    end
    chk("wg_count", wg_cnt, 32'd1);
    chk("wg_position", wg_at, 32'd7);
`else
    wg_cnt = 0;
    wg_at = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
